// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the shared status LED: latches per-source requests, grants one
// at a time and plays that source's blink code (index+1 blinks of HOLD on / GAP off).
module led_blink_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned HOLD = 250,
  parameter int unsigned GAP  = 250
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic            led,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done
);

  localparam int unsigned MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW    = $clog2(MAXHG + 1);
  localparam int unsigned BW    = $clog2(NREQ + 1);
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ == 0 || NREQ > 8) begin : g_bad_nreq
    $error("led_blink_arbiter: NREQ must be in 1..8");
  end
  if (HOLD == 0) begin : g_bad_hold
    $error("led_blink_arbiter: HOLD must be >= 1");
  end
  if (GAP == 0) begin : g_bad_gap
    $error("led_blink_arbiter: GAP must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [NREQ-1:0] r_pending, w_pend_nxt;
  logic [PW-1:0]   r_ptr,     w_ptr_nxt;
  logic [CW-1:0]   r_cnt,     w_cnt_nxt;
  logic [BW-1:0]   r_blinks,  w_blinks_nxt;
  logic            r_led,     w_led_nxt;
  logic [NREQ-1:0] r_grant,   w_grant_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;

  logic            w_hit_hi;
  logic [PW-1:0]   w_win_hi;
  logic [PW-1:0]   w_win_lo;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_clr;

  // Round-robin pick: lowest pending index above ptr, else lowest pending index overall.
  always_comb begin
    w_hit_hi = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (r_pending[j]) begin
        if (PW'(j) > r_ptr) begin
          w_hit_hi = 1'b1;
          w_win_hi = PW'(j);
        end else begin
          w_win_lo = PW'(j);
        end
      end
    end
    w_win    = w_hit_hi ? w_win_hi : w_win_lo;
    w_win_oh = NREQ'(1) << w_win;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_blinks_nxt = r_blinks;
    w_led_nxt    = r_led;
    w_grant_nxt  = r_grant;
    w_done_nxt   = 1'b0;
    w_clr        = '0;

    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_state_nxt  = S_ON;
          w_grant_nxt  = w_win_oh;
          w_clr        = w_win_oh;
          w_ptr_nxt    = w_win;
          w_blinks_nxt = BW'(w_win) + BW'(1);
          w_cnt_nxt    = CW'(HOLD - 1);
          w_led_nxt    = 1'b1;
        end
      end
      S_ON: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_OFF;
          w_led_nxt    = 1'b0;
          w_cnt_nxt    = CW'(GAP - 1);
          w_blinks_nxt = r_blinks - BW'(1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_OFF: begin
        if (r_cnt == '0) begin
          if (r_blinks != '0) begin
            w_state_nxt = S_ON;
            w_led_nxt   = 1'b1;
            w_cnt_nxt   = CW'(HOLD - 1);
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = 1'b0;
        w_grant_nxt = '0;
      end
    endcase

    // A request on the granting edge re-queues its source rather than being lost.
    w_pend_nxt = (r_pending & ~w_clr) | req;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_ptr     <= PW'(NREQ - 1);
      r_cnt     <= '0;
      r_blinks  <= '0;
      r_led     <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_blinks  <= w_blinks_nxt;
      r_led     <= w_led_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign led   = r_led;
  assign grant = r_grant;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter: HOLD=4/GAP=3 instance plus a default-parameter
// instance; outputs are driven and sampled on the falling clock edge.
module tb_led_blink_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] req_d;
  logic       led,   busy,   done;
  logic [2:0] grant;
  logic       led_d, busy_d, done_d;
  logic [2:0] grant_d;

  int         n_vec;
  int         n_err;
  logic [5:0] exp_f;

  led_blink_arbiter #(.NREQ(3), .HOLD(4), .GAP(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .led   (led),
    .grant (grant),
    .busy  (busy),
    .done  (done)
  );

  led_blink_arbiter u_dut_def (
    .clk   (clk),
    .reset (reset),
    .req   (req_d),
    .led   (led_d),
    .grant (grant_d),
    .busy  (busy_d),
    .done  (done_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {led, grant, busy, done} for code idx owned by g, t samples after led rise (HOLD=4, GAP=3).
  function automatic logic [5:0] frame(input int idx, input logic [2:0] g, input int t);
    if (t < (idx + 1) * 7)       return {1'((t % 7) < 4), g, 1'b1, 1'b0};
    else if (t == (idx + 1) * 7) return 6'b0_000_0_1;
    else                         return 6'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req   = 3'b000;
    req_d = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [2:0] v);
    req = v;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 3'b111;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n_vec++;
      if ({led, grant, busy, done} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_hold t=%0d got %b expected %b", t, {led, grant, busy, done}, 6'b0);
      end
    end
    reset = 1'b1;
    req   = 3'b000;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_vec++;
      if ({led, grant, busy, done} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_idle t=%0d got %b expected %b", t, {led, grant, busy, done}, 6'b0);
      end
    end
  endtask

  task automatic test_single_req0();
    do_reset();
    pulse(3'b001);
    for (int t = 0; t <= 9; t++) begin
      @(negedge clk);
      exp_f = frame(0, 3'b001, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL single_req0 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
  endtask

  task automatic test_req2();
    do_reset();
    pulse(3'b100);
    for (int t = 0; t <= 23; t++) begin
      @(negedge clk);
      exp_f = frame(2, 3'b100, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL req2_code t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(3'b101);
    for (int t = 0; t <= 7; t++) begin
      @(negedge clk);
      exp_f = frame(0, 3'b001, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL b2b_code0 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
    // Next code must rise exactly one clock after done.
    for (int t = 0; t <= 22; t++) begin
      @(negedge clk);
      exp_f = frame(2, 3'b100, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL b2b_code2 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
  endtask

  task automatic test_held_alternate();
    do_reset();
    req = 3'b011;
    @(negedge clk);
    req = 3'b001;
    for (int t = 0; t <= 7; t++) begin
      @(negedge clk);
      exp_f = frame(0, 3'b001, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL held_first0 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
    for (int t = 0; t <= 14; t++) begin
      @(negedge clk);
      exp_f = frame(1, 3'b010, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL held_then1 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
    for (int t = 0; t <= 7; t++) begin
      @(negedge clk);
      exp_f = frame(0, 3'b001, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL held_again0 t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
    req = 3'b000;
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(3'b010);
    for (int t = 0; t <= 2; t++) begin
      @(negedge clk);
      req   = (t == 1) ? 3'b001 : 3'b000;
      exp_f = frame(1, 3'b010, t);
      n_vec++;
      if ({led, grant, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL async_pre t=%0d got %b expected %b", t, {led, grant, busy, done}, exp_f);
      end
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({led, grant, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL async_drop got %b expected %b", {led, grant, busy, done}, 6'b0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_vec++;
      if ({led, grant, busy, done} !== 6'b0) begin
        n_err++;
        $display("FAIL async_no_resume t=%0d got %b expected %b", t, {led, grant, busy, done}, 6'b0);
      end
    end
  endtask

  task automatic test_default_params();
    do_reset();
    req_d = 3'b001;
    @(negedge clk);
    req_d = 3'b000;
    for (int t = 0; t <= 501; t++) begin
      @(negedge clk);
      if (t < 500)       exp_f = {1'(t < 250), 3'b001, 1'b1, 1'b0};
      else if (t == 500) exp_f = 6'b0_000_0_1;
      else               exp_f = 6'b0;
      n_vec++;
      if ({led_d, grant_d, busy_d, done_d} !== exp_f) begin
        n_err++;
        $display("FAIL default_blink t=%0d got %b expected %b", t, {led_d, grant_d, busy_d, done_d}, exp_f);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req   = 3'b000;
    req_d = 3'b000;
    test_reset();
    test_single_req0();
    test_req2();
    test_back_to_back();
    test_held_alternate();
    test_async_reset();
    test_default_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1);
  end

endmodule
